// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// =============================================================================
// pipe_hazard_ctrl_pkg : shared types for the 5-stage pipeline hazard controller
// Rev 1.0 : initial release
// =============================================================================
package pipe_hazard_ctrl_pkg;

  localparam int RDC_W = 3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2
  } hz_state_e;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic flush_id;
    logic flush_ex;
    logic bubble_wb;
    logic pc_sel_redirect;
  } pipe_stall_t;

  // Whole-pipe freeze used while a data-memory access is outstanding.
  function automatic pipe_stall_t freeze_ctrl();
    pipe_stall_t c;
    c           = '0;
    c.stall_if  = 1'b1;
    c.stall_id  = 1'b1;
    c.stall_ex  = 1'b1;
    c.stall_mem = 1'b1;
    c.bubble_wb = 1'b1;
    return c;
  endfunction

  function automatic pipe_stall_t redirect_ctrl();
    pipe_stall_t c;
    c                 = '0;
    c.pc_sel_redirect = 1'b1;
    c.flush_id        = 1'b1;
    c.flush_ex        = 1'b1;
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// =============================================================================
// pipe_hazard_ctrl_if : pipeline <-> hazard controller signal bundle
// Rev 1.0 : initial release (perf ports under PIPE_HAZARD_PERF_EN)
// =============================================================================
interface pipe_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1_addr;
  logic [REG_ADDR_W-1:0] id_rs2_addr;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic                  ex_valid;
  logic                  ex_is_load;
  logic [REG_ADDR_W-1:0] ex_rd_addr;
  logic                  ex_redirect;
  logic                  mem_valid;
  logic                  mem_wb_en;
  logic [REG_ADDR_W-1:0] mem_rd_addr;
  logic                  mem_req;
  logic                  mem_ack;
  logic                  wb_valid;
  logic                  wb_wb_en;
  logic [REG_ADDR_W-1:0] wb_rd_addr;

  logic                  stall_if;
  logic                  stall_id;
  logic                  stall_ex;
  logic                  stall_mem;
  logic                  flush_id;
  logic                  flush_ex;
  logic                  bubble_wb;
  logic                  pc_sel_redirect;
  logic [1:0]            fwd_rs1;
  logic [1:0]            fwd_rs2;
  logic                  mem_err;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0]           perf_load_use;
  logic [31:0]           perf_mem_wait;
  logic [31:0]           perf_redirect;
`endif

  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
    output ex_valid, ex_is_load, ex_rd_addr, ex_redirect,
    output mem_valid, mem_wb_en, mem_rd_addr, mem_req, mem_ack,
    output wb_valid, wb_wb_en, wb_rd_addr,
    input  stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
    input  bubble_wb, pc_sel_redirect, fwd_rs1, fwd_rs2, mem_err
`ifdef PIPE_HAZARD_PERF_EN
    , input perf_load_use, perf_mem_wait, perf_redirect
`endif
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
    input  ex_valid, ex_is_load, ex_rd_addr, ex_redirect,
    input  mem_valid, mem_wb_en, mem_rd_addr, mem_req, mem_ack,
    input  wb_valid, wb_wb_en, wb_rd_addr,
    output stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
    output bubble_wb, pc_sel_redirect, fwd_rs1, fwd_rs2, mem_err
`ifdef PIPE_HAZARD_PERF_EN
    , output perf_load_use, perf_mem_wait, perf_redirect
`endif
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
`default_nettype none
// =============================================================================
// pipe_hazard_ctrl_fwd_unit : operand forwarding select for one ID source
// Rev 1.0 : initial release
// =============================================================================
module pipe_hazard_ctrl_fwd_unit
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic                  mem_valid,
  input  logic                  mem_wb_en,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic                  wb_valid,
  input  logic                  wb_wb_en,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  output fwd_sel_e              sel
);
  logic hit_mem;
  logic hit_wb;

  assign hit_mem = mem_valid & mem_wb_en & (mem_rd_addr != '0) & (mem_rd_addr == rs_addr);
  assign hit_wb  = wb_valid & wb_wb_en & (wb_rd_addr != '0) & (wb_rd_addr == rs_addr);

  // The younger producer in EX/MEM holds the newest value.
  assign sel = hit_mem ? FWD_EXMEM : (hit_wb ? FWD_MEMWB : FWD_RF);
endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// =============================================================================
// pipe_hazard_ctrl : load-use/memory-wait/redirect sequencing and forwarding
// Rev 1.0 : initial release; PIPE_HAZARD_PERF_EN adds performance counters
// =============================================================================
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W      = 5,
  parameter int REDIRECT_CYCLES = 2,
  parameter int MEM_TIMEOUT     = 255
) (
  input logic               clk,
  input logic               nrst,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int               TMO_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [RDC_W-1:0] RDC_LOAD = RDC_W'(REDIRECT_CYCLES - 1);

  hz_state_e         state_q, state_d;
  logic [RDC_W-1:0]  rdc_q, rdc_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  pipe_stall_t       ctrl;
  logic              mem_err_c;
  logic              load_use;
  logic              mem_stall;
  fwd_sel_e          fwd1, fwd2;

  assign load_use  = hz.id_valid & hz.ex_valid & hz.ex_is_load & (hz.ex_rd_addr != '0) &
                     ((hz.id_rs1_used & (hz.id_rs1_addr == hz.ex_rd_addr)) |
                      (hz.id_rs2_used & (hz.id_rs2_addr == hz.ex_rd_addr)));
  assign mem_stall = hz.mem_valid & hz.mem_req & ~hz.mem_ack;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= RUN;
      rdc_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      rdc_q   <= rdc_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rdc_d     = rdc_q;
    tmo_d     = '0;
    ctrl      = '0;
    mem_err_c = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          ctrl    = freeze_ctrl();
          state_d = MEM_WAIT;
        end else if (hz.ex_redirect) begin
          ctrl    = redirect_ctrl();
          rdc_d   = RDC_LOAD;
          state_d = (RDC_LOAD != '0) ? REDIRECT : RUN;
        end else if (load_use) begin
          ctrl.stall_if = 1'b1;
          ctrl.stall_id = 1'b1;
          ctrl.flush_ex = 1'b1;
        end
      end
      MEM_WAIT: begin
        // A redirect interrupted by the memory wait resumes after the ack.
        if (hz.mem_ack) begin
          state_d = (rdc_q != '0) ? REDIRECT : RUN;
        end else begin
          ctrl      = freeze_ctrl();
          tmo_d     = tmo_q + TMO_W'(1);
          mem_err_c = (MEM_TIMEOUT != 0) && (tmo_q == TMO_W'(MEM_TIMEOUT));
        end
      end
      REDIRECT: begin
        if (mem_stall) begin
          ctrl          = freeze_ctrl();
          ctrl.flush_id = 1'b1;
          state_d       = MEM_WAIT;
        end else if (hz.ex_redirect) begin
          ctrl    = redirect_ctrl();
          rdc_d   = RDC_LOAD;
          state_d = (RDC_LOAD != '0) ? REDIRECT : RUN;
        end else begin
          ctrl.flush_id = 1'b1;
          rdc_d         = rdc_q - RDC_W'(1);
          if (rdc_q == RDC_W'(1)) state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        rdc_d   = '0;
      end
    endcase
  end

  pipe_hazard_ctrl_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .rs_addr     (hz.id_rs1_addr),
    .mem_valid   (hz.mem_valid),
    .mem_wb_en   (hz.mem_wb_en),
    .mem_rd_addr (hz.mem_rd_addr),
    .wb_valid    (hz.wb_valid),
    .wb_wb_en    (hz.wb_wb_en),
    .wb_rd_addr  (hz.wb_rd_addr),
    .sel         (fwd1)
  );

  pipe_hazard_ctrl_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .rs_addr     (hz.id_rs2_addr),
    .mem_valid   (hz.mem_valid),
    .mem_wb_en   (hz.mem_wb_en),
    .mem_rd_addr (hz.mem_rd_addr),
    .wb_valid    (hz.wb_valid),
    .wb_wb_en    (hz.wb_wb_en),
    .wb_rd_addr  (hz.wb_rd_addr),
    .sel         (fwd2)
  );

  // While in reset the pipe is held empty: flushes forced, everything else quiet.
  assign hz.stall_if        = nrst & ctrl.stall_if;
  assign hz.stall_id        = nrst & ctrl.stall_id;
  assign hz.stall_ex        = nrst & ctrl.stall_ex;
  assign hz.stall_mem       = nrst & ctrl.stall_mem;
  assign hz.flush_id        = ~nrst | ctrl.flush_id;
  assign hz.flush_ex        = ~nrst | ctrl.flush_ex;
  assign hz.bubble_wb       = ~nrst | ctrl.bubble_wb;
  assign hz.pc_sel_redirect = nrst & ctrl.pc_sel_redirect;
  assign hz.mem_err         = nrst & mem_err_c;
  assign hz.fwd_rs1         = nrst ? fwd1 : FWD_RF;
  assign hz.fwd_rs2         = nrst ? fwd2 : FWD_RF;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_lu_q, perf_lu_d;
  logic [31:0] perf_mw_q, perf_mw_d;
  logic [31:0] perf_rd_q, perf_rd_d;

  always_comb begin
    perf_lu_d = perf_lu_q;
    perf_mw_d = perf_mw_q;
    perf_rd_d = perf_rd_q;
    if ((state_q == RUN) && !mem_stall && !hz.ex_redirect && load_use)
      perf_lu_d = perf_lu_q + 32'd1;
    if (state_q == MEM_WAIT)
      perf_mw_d = perf_mw_q + 32'd1;
    if (ctrl.pc_sel_redirect)
      perf_rd_d = perf_rd_q + 32'd1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      perf_lu_q <= '0;
      perf_mw_q <= '0;
      perf_rd_q <= '0;
    end else begin
      perf_lu_q <= perf_lu_d;
      perf_mw_q <= perf_mw_d;
      perf_rd_q <= perf_rd_d;
    end
  end

  assign hz.perf_load_use = perf_lu_q;
  assign hz.perf_mem_wait = perf_mw_q;
  assign hz.perf_redirect = perf_rd_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// =============================================================================
// tb_pipe_hazard_ctrl : directed self-checking bench (REDIRECT_CYCLES=3, MEM_TIMEOUT=4)
// Rev 1.0 : initial release
// =============================================================================
module tb_pipe_hazard_ctrl;
  // {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, bubble_wb, pc_sel_redirect}
  localparam logic [7:0] C_NONE    = 8'b0000_0000;
  localparam logic [7:0] C_RST     = 8'b0000_1110;
  localparam logic [7:0] C_LU      = 8'b1100_0100;
  localparam logic [7:0] C_FRZ     = 8'b1111_0010;
  localparam logic [7:0] C_FRZ_FID = 8'b1111_1010;
  localparam logic [7:0] C_RDR     = 8'b0000_1101;
  localparam logic [7:0] C_FID     = 8'b0000_1000;

  logic       clk;
  logic       nrst;
  logic [7:0] ctl;
  int         n_cmp;
  int         n_err;

  pipe_hazard_ctrl_if #(.REG_ADDR_W(5)) hz_if ();

  pipe_hazard_ctrl #(
    .REG_ADDR_W      (5),
    .REDIRECT_CYCLES (3),
    .MEM_TIMEOUT     (4)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .hz   (hz_if)
  );

  assign ctl = {hz_if.stall_if, hz_if.stall_id, hz_if.stall_ex, hz_if.stall_mem,
                hz_if.flush_id, hz_if.flush_ex, hz_if.bubble_wb, hz_if.pc_sel_redirect};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz_if.id_valid    = 1'b0;
    hz_if.id_rs1_addr = '0;
    hz_if.id_rs2_addr = '0;
    hz_if.id_rs1_used = 1'b0;
    hz_if.id_rs2_used = 1'b0;
    hz_if.ex_valid    = 1'b0;
    hz_if.ex_is_load  = 1'b0;
    hz_if.ex_rd_addr  = '0;
    hz_if.ex_redirect = 1'b0;
    hz_if.mem_valid   = 1'b0;
    hz_if.mem_wb_en   = 1'b0;
    hz_if.mem_rd_addr = '0;
    hz_if.mem_req     = 1'b0;
    hz_if.mem_ack     = 1'b0;
    hz_if.wb_valid    = 1'b0;
    hz_if.wb_wb_en    = 1'b0;
    hz_if.wb_rd_addr  = '0;
  endtask

  task automatic chk(input string tag, input logic [7:0] exp_ctl, input logic exp_err);
    @(negedge clk);
    n_cmp++;
    assert (ctl === exp_ctl) else begin
      n_err++;
      $error("FAIL %s ctl: observed %b expected %b", tag, ctl, exp_ctl);
    end
    n_cmp++;
    assert (hz_if.mem_err === exp_err) else begin
      n_err++;
      $error("FAIL %s mem_err: observed %b expected %b", tag, hz_if.mem_err, exp_err);
    end
  endtask

  task automatic chk_fwd(input string tag, input logic [1:0] e1, input logic [1:0] e2);
    n_cmp++;
    assert (hz_if.fwd_rs1 === e1) else begin
      n_err++;
      $error("FAIL %s fwd_rs1: observed %b expected %b", tag, hz_if.fwd_rs1, e1);
    end
    n_cmp++;
    assert (hz_if.fwd_rs2 === e2) else begin
      n_err++;
      $error("FAIL %s fwd_rs2: observed %b expected %b", tag, hz_if.fwd_rs2, e2);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    nrst  = 1'b0;
    idle();
    // Forwarding match present during reset must stay masked.
    hz_if.id_rs1_addr = 5'd3;
    hz_if.mem_valid   = 1'b1;
    hz_if.mem_wb_en   = 1'b1;
    hz_if.mem_rd_addr = 5'd3;
    chk("reset", C_RST, 1'b0);
    chk_fwd("reset_fwd", 2'b00, 2'b00);
    tick();
    nrst = 1'b1;
    idle();
    chk("idle", C_NONE, 1'b0);

    // Load-use on rs1, then release with zero-wait memory access and forwarding.
    tick();
    hz_if.id_valid = 1'b1; hz_if.id_rs1_addr = 5'd5; hz_if.id_rs1_used = 1'b1;
    hz_if.ex_valid = 1'b1; hz_if.ex_is_load = 1'b1; hz_if.ex_rd_addr = 5'd5;
    chk("lu_rs1", C_LU, 1'b0);
    tick();
    hz_if.ex_valid = 1'b0; hz_if.ex_is_load = 1'b0; hz_if.ex_rd_addr = '0;
    hz_if.mem_valid = 1'b1; hz_if.mem_wb_en = 1'b1; hz_if.mem_rd_addr = 5'd5;
    hz_if.mem_req = 1'b1; hz_if.mem_ack = 1'b1;
    chk("lu_release", C_NONE, 1'b0);
    chk_fwd("lu_fwd", 2'b01, 2'b00);

    tick();
    idle();
    hz_if.id_valid = 1'b1; hz_if.id_rs1_used = 1'b1;
    hz_if.ex_valid = 1'b1; hz_if.ex_is_load = 1'b1;
    chk("lu_x0", C_NONE, 1'b0);
    tick();
    hz_if.id_rs2_addr = 5'd7; hz_if.ex_rd_addr = 5'd7;
    chk("lu_rs2_unused", C_NONE, 1'b0);
    tick();
    hz_if.id_rs2_used = 1'b1;
    chk("lu_rs2", C_LU, 1'b0);

    // Forwarding priority and x0 exclusion.
    tick();
    idle();
    hz_if.id_rs1_addr = 5'd3;
    hz_if.mem_valid = 1'b1; hz_if.mem_wb_en = 1'b1; hz_if.mem_rd_addr = 5'd3;
    hz_if.wb_valid  = 1'b1; hz_if.wb_wb_en  = 1'b1; hz_if.wb_rd_addr  = 5'd3;
    chk("fwd_exmem_ctl", C_NONE, 1'b0);
    chk_fwd("fwd_exmem", 2'b01, 2'b00);
    tick();
    hz_if.mem_wb_en = 1'b0; hz_if.id_rs2_addr = 5'd3;
    chk("fwd_memwb_ctl", C_NONE, 1'b0);
    chk_fwd("fwd_memwb", 2'b10, 2'b10);
    tick();
    hz_if.id_rs1_addr = '0; hz_if.mem_rd_addr = '0; hz_if.mem_wb_en = 1'b1; hz_if.wb_rd_addr = '0;
    chk("fwd_x0_ctl", C_NONE, 1'b0);
    chk_fwd("fwd_x0", 2'b00, 2'b00);

    // Four-cycle memory wait; redirect and load-use ignored while waiting.
    tick();
    idle();
    hz_if.mem_valid = 1'b1; hz_if.mem_req = 1'b1;
    chk("mw_enter", C_FRZ, 1'b0);
    tick();
    hz_if.ex_redirect = 1'b1;
    hz_if.id_valid = 1'b1; hz_if.id_rs1_addr = 5'd5; hz_if.id_rs1_used = 1'b1;
    hz_if.ex_valid = 1'b1; hz_if.ex_is_load = 1'b1; hz_if.ex_rd_addr = 5'd5;
    chk("mw_1_ignore", C_FRZ, 1'b0);
    tick();
    chk("mw_2", C_FRZ, 1'b0);
    tick();
    chk("mw_3", C_FRZ, 1'b0);
    tick();
    hz_if.ex_redirect = 1'b0; hz_if.mem_ack = 1'b1;
    chk("mw_ack", C_NONE, 1'b0);
    tick();
    hz_if.mem_req = 1'b0; hz_if.mem_ack = 1'b0; hz_if.mem_valid = 1'b0;
    chk("mw_after_run", C_LU, 1'b0);

    // Redirect window of three flush_id cycles.
    tick();
    idle();
    hz_if.ex_redirect = 1'b1;
    chk("rd_0", C_RDR, 1'b0);
    tick();
    hz_if.ex_redirect = 1'b0;
    chk("rd_1", C_FID, 1'b0);
    tick();
    chk("rd_2", C_FID, 1'b0);
    tick();
    chk("rd_3", C_NONE, 1'b0);

    // Memory stall interrupting the redirect window, then resume.
    tick();
    hz_if.ex_redirect = 1'b1;
    chk("rs_0", C_RDR, 1'b0);
    tick();
    hz_if.ex_redirect = 1'b0;
    chk("rs_1", C_FID, 1'b0);
    tick();
    hz_if.mem_valid = 1'b1; hz_if.mem_req = 1'b1;
    chk("rs_2_stall", C_FRZ_FID, 1'b0);
    tick();
    chk("rs_3_wait", C_FRZ, 1'b0);
    tick();
    hz_if.mem_ack = 1'b1;
    chk("rs_4_ack", C_NONE, 1'b0);
    tick();
    hz_if.mem_valid = 1'b0; hz_if.mem_req = 1'b0; hz_if.mem_ack = 1'b0;
    chk("rs_5_resume", C_FID, 1'b0);
    tick();
    chk("rs_6", C_NONE, 1'b0);

    // Back-to-back redirect reloads the window.
    tick();
    hz_if.ex_redirect = 1'b1;
    chk("rr_0", C_RDR, 1'b0);
    tick();
    chk("rr_1_reload", C_RDR, 1'b0);
    tick();
    hz_if.ex_redirect = 1'b0;
    chk("rr_2", C_FID, 1'b0);
    tick();
    chk("rr_3", C_FID, 1'b0);
    tick();
    chk("rr_4", C_NONE, 1'b0);

    // Timeout: mem_err pulses once after four MEM_WAIT cycles, then async reset.
    tick();
    hz_if.mem_valid = 1'b1; hz_if.mem_req = 1'b1;
    chk("to_enter", C_FRZ, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("to_wait%0d", i), C_FRZ, (i == 5));
    end
    tick();
    nrst = 1'b0;
    chk("to_reset", C_RST, 1'b0);
    chk_fwd("to_reset_fwd", 2'b00, 2'b00);
    tick();
    nrst = 1'b1;
    idle();
    chk("to_after", C_NONE, 1'b0);

    // Asynchronous reset in the middle of a redirect window.
    tick();
    hz_if.ex_redirect = 1'b1;
    chk("rdr_0", C_RDR, 1'b0);
    tick();
    hz_if.ex_redirect = 1'b0;
    nrst = 1'b0;
    chk("rdr_reset", C_RST, 1'b0);
    tick();
    nrst = 1'b1;
    chk("rdr_after", C_NONE, 1'b0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
